// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and constants for the neuron weighted-sum stage
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2
    } state_t;

    localparam int SAMPLE_W = 8;
    localparam int OFFSET   = 128;
    localparam int SAT_MAX  = 127;
    localparam int SAT_MIN  = -128;

endpackage

// File: rtl/mac_scale_sat.sv
// rtl/mac_scale_sat.sv - shift, clamp and offset-binary conversion of an accumulator
import neuron_pkg::*;

module mac_scale_sat #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic        [SAMPLE_W-1:0] sum
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN);

    logic signed [ACC_W-1:0] s;

    assign s = acc >>> SHIFT;

    // Adding OFFSET to an in-range two's complement byte is the same as flipping its MSB.
    always_comb begin
        sum = 8'(OFFSET);
        if (s > MAX_V) begin
            sum = 8'(SAT_MAX + OFFSET);
        end else if (s < MIN_V) begin
            sum = 8'(SAT_MIN + OFFSET);
        end else begin
            sum = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with scaled, saturated offset-binary output
import neuron_pkg::*;

module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [15:0]         bias,
    input  logic signed [SAMPLE_W-1:0] x_in,
    input  logic signed [SAMPLE_W-1:0] w_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic        [SAMPLE_W-1:0] sum_out,
    output logic                       data_ready,
    output logic                       done
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t                  state, next_state;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic signed [15:0]      prod;
    logic                    beat;
    logic        [SAMPLE_W-1:0] scaled;

    assign prod = x_in * w_in;
    assign beat = in_valid && in_ready;

    mac_scale_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_scale (
        .acc (acc),
        .sum (scaled)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACC;
            ACC:     if (beat && cnt == LAST) next_state = SCALE;
            SCALE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sum_out    <= 8'(OFFSET);
            data_ready <= 1'b1;
            done       <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state    <= next_state;
            done     <= 1'b0;
            // Registered ready tracks the next state, so it falls on the same edge as the final beat.
            in_ready <= (next_state == ACC);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= ACC_W'(bias);
                        cnt        <= '0;
                        data_ready <= 1'b1;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= acc + ACC_W'(prod);
                        cnt <= cnt + 1'b1;
                    end
                end
                SCALE: begin
                    sum_out    <= scaled;
                    data_ready <= 1'b0;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - randomized self-checking bench for neuron_mac
module tb_neuron_mac;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic signed [15:0] bias = '0;
    logic signed [7:0] x_in = '0;
    logic signed [7:0] w_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic        [7:0] sum_out;
    logic              data_ready;
    logic              done;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(4), .ACC_W(24), .SHIFT(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias       (bias),
        .x_in       (x_in),
        .w_in       (w_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_out    (sum_out),
        .data_ready (data_ready),
        .done       (done)
    );

    // floor(sum / 64), clamped to a signed byte, then shifted to offset binary
    function automatic logic [7:0] model(input int b, input int xs[4], input int ws[4]);
        int sum;
        int s;
        sum = b;
        for (int i = 0; i < 4; i++) sum += xs[i] * ws[i];
        if (sum >= 0) s = sum / 64;
        else s = -((-sum + 63) / 64);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s + 128);
    endfunction

    task automatic run_eval(input int b, input int xs[4], input int ws[4], input int gap,
                            input bit poke_start, output logic [7:0] sum_o, output logic done_o,
                            output logic dr_o, output logic ir_after, output logic done_next,
                            output logic ir_ok);
        ir_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        bias  = 16'(b);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                x_in = 8'($urandom);
                w_in = 8'($urandom);
                start = poke_start && (i == 1) && (g == 0);
                bias  = start ? 16'sd12345 : bias;
                @(negedge clk);
                start = 1'b0;
            end
            if (in_ready !== 1'b1) ir_ok = 1'b0;
            in_valid = 1'b1;
            x_in = 8'(xs[i]);
            w_in = 8'(ws[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ir_after = in_ready;
        @(negedge clk);
        sum_o  = sum_out;
        done_o = done;
        dr_o   = data_ready;
        @(negedge clk);
        done_next = done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt += 4;
        if (sum_out !== 8'h80) $display("FAIL reset_sum_out got=%h exp=80", sum_out); else pass_cnt++;
        if (data_ready !== 1'b1) $display("FAIL reset_data_ready got=%b exp=1", data_ready); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    endtask

    task automatic test_case(input string name, input int b, input int xs[4], input int ws[4],
                             input int gap, input bit poke);
        logic [7:0] s;
        logic d, dr, ira, dn, iok;
        logic [7:0] exp_s;
        exp_s = model(b, xs, ws);
        run_eval(b, xs, ws, gap, poke, s, d, dr, ira, dn, iok);
        total_cnt += 6;
        if (s !== exp_s) $display("FAIL %s sum_out got=%h exp=%h", name, s, exp_s); else pass_cnt++;
        if (d !== 1'b1) $display("FAIL %s done got=%b exp=1", name, d); else pass_cnt++;
        if (dr !== 1'b0) $display("FAIL %s data_ready got=%b exp=0", name, dr); else pass_cnt++;
        if (ira !== 1'b0) $display("FAIL %s in_ready_after_last got=%b exp=0", name, ira); else pass_cnt++;
        if (dn !== 1'b0) $display("FAIL %s done_width got=%b exp=0", name, dn); else pass_cnt++;
        if (iok !== 1'b1) $display("FAIL %s in_ready_during_acc got=%b exp=1", name, iok); else pass_cnt++;
    endtask

    task automatic test_basic();
        int xs[4] = '{64, 64, 64, 64};
        int ws[4] = '{16, 16, 16, 16};
        test_case("basic", 0, xs, ws, 0, 1'b0);
        total_cnt++;
        if (sum_out !== 8'hC0) $display("FAIL basic_const got=%h exp=c0", sum_out); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int xp[4] = '{127, 127, 127, 127};
        int xn[4] = '{-128, -128, -128, -128};
        int ws[4] = '{127, 127, 127, 127};
        test_case("sat_hi", 0, xp, ws, 0, 1'b0);
        test_case("sat_lo", 0, xn, ws, 0, 1'b0);
    endtask

    task automatic test_bias();
        int xs[4] = '{0, 0, 0, 0};
        int ws[4] = '{5, -7, 100, -128};
        test_case("bias_m640", -640, xs, ws, 0, 1'b0);
        test_case("bias_m1", -1, xs, ws, 0, 1'b0);
    endtask

    task automatic test_stalls();
        int xs[4] = '{64, 64, 64, 64};
        int ws[4] = '{16, 16, 16, 16};
        test_case("stall_poke", 0, xs, ws, 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        int xs[4] = '{64, 64, 64, 64};
        int ws[4] = '{16, 16, 16, 16};
        @(negedge clk);
        start = 1'b1;
        bias  = 16'sd3000;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x_in = 8'sd100;
            w_in = 8'sd100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        @(negedge clk);
        total_cnt += 4;
        if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", in_ready); else pass_cnt++;
        if (data_ready !== 1'b1) $display("FAIL midrst_data_ready got=%b exp=1", data_ready); else pass_cnt++;
        if (sum_out !== 8'h80) $display("FAIL midrst_sum_out got=%h exp=80", sum_out); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else pass_cnt++;
        test_case("after_midrst", 0, xs, ws, 0, 1'b0);
    endtask

    task automatic test_random();
        int xs[4];
        int ws[4];
        int b;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = int'($urandom_range(255)) - 128;
                ws[i] = int'($urandom_range(255)) - 128;
            end
            b = (n % 3 == 0) ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(4095)) - 2048;
            test_case($sformatf("rand%0d", n), b, xs, ws, int'($urandom_range(2)), n[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_bias();
        test_stalls();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
